// File: rtl/alu_operand_stage.sv
// Decode/issue stage ahead of the mips32 ALU: decodes select and operands, then registers them
// behind a valid/ready handshake with a one-entry skid buffer and a flopped in_ready.
module alu_operand_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_select,
   output logic [4:0]  dest_reg,
   output logic        illegal
);

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  sel;
      logic [4:0]  dest;
      logic        illegal;
   } bundle_t;

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   localparam logic [2:0] SelAnd = 3'b000;
   localparam logic [2:0] SelOr  = 3'b001;
   localparam logic [2:0] SelAdd = 3'b010;
   localparam logic [2:0] SelXor = 3'b011;
   localparam logic [2:0] SelSub = 3'b100;
   localparam logic [2:0] SelSrl = 3'b101;
   localparam logic [2:0] SelSll = 3'b110;
   localparam logic [2:0] SelNor = 3'b111;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rt_idx;
   logic [4:0]  rd_idx;
   logic [4:0]  shamt;
   logic [15:0] imm;
   logic        unused_rs_idx;

   assign opcode        = instr[31:26];
   assign rt_idx        = instr[20:16];
   assign rd_idx        = instr[15:11];
   assign shamt         = instr[10:6];
   assign funct         = instr[5:0];
   assign imm           = instr[15:0];
   // rs index is resolved by the register file; only its data is consumed here
   assign unused_rs_idx = ^instr[25:21];

   bundle_t dec;

   always_comb begin
      dec         = '0;
      dec.illegal = 1'b1;
      if (opcode == 6'b000000) begin
         dec.a       = rs_data;
         dec.b       = rt_data;
         dec.dest    = rd_idx;
         dec.illegal = 1'b0;
         case (funct)
            6'b100100:            dec.sel = SelAnd;
            6'b100101:            dec.sel = SelOr;
            6'b100000, 6'b100001: dec.sel = SelAdd;
            6'b100110:            dec.sel = SelXor;
            6'b100010, 6'b100011: dec.sel = SelSub;
            6'b100111:            dec.sel = SelNor;
            6'b000010: begin
               dec.sel = SelSrl;
               dec.a   = rt_data;
               dec.b   = {27'b0, shamt};
            end
            6'b000000: begin
               dec.sel = SelSll;
               dec.a   = rt_data;
               dec.b   = {27'b0, shamt};
            end
            6'b000110: begin
               dec.sel = SelSrl;
               dec.a   = rt_data;
               dec.b   = {27'b0, rs_data[4:0]};
            end
            6'b000100: begin
               dec.sel = SelSll;
               dec.a   = rt_data;
               dec.b   = {27'b0, rs_data[4:0]};
            end
            default: dec = '{a: '0, b: '0, sel: SelAnd, dest: '0, illegal: 1'b1};
         endcase
      end else begin
         dec.a       = rs_data;
         dec.dest    = rt_idx;
         dec.illegal = 1'b0;
         case (opcode)
            6'b001000, 6'b001001: begin
               dec.sel = SelAdd;
               dec.b   = {{16{imm[15]}}, imm};
            end
            6'b001100: begin
               dec.sel = SelAnd;
               dec.b   = {16'b0, imm};
            end
            6'b001101: begin
               dec.sel = SelOr;
               dec.b   = {16'b0, imm};
            end
            6'b001110: begin
               dec.sel = SelXor;
               dec.b   = {16'b0, imm};
            end
            6'b001111: begin
               dec.sel = SelSll;
               dec.a   = {16'b0, imm};
               dec.b   = 32'd16;
            end
            default: dec = '{a: '0, b: '0, sel: SelAnd, dest: '0, illegal: 1'b1};
         endcase
      end
   end

   state_e  state_q, state_d;
   bundle_t out_q, out_d;
   bundle_t skid_q, skid_d;
   logic    in_ready_q;
   logic    accept;

   assign accept = in_valid & in_ready_q;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_d = StOne;
                  out_d   = dec;
               end
            end
            StOne: begin
               if (accept && out_ready) begin
                  out_d = dec;
               end else if (accept) begin
                  state_d = StTwo;
                  skid_d  = dec;
               end else if (out_ready) begin
                  state_d = StEmpty;
               end
            end
            StTwo: begin
               if (out_ready) begin
                  state_d = StOne;
                  out_d   = skid_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StEmpty;
         out_q      <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != StTwo);
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = (state_q != StEmpty);
   assign alu_a      = out_q.a;
   assign alu_b      = out_q.b;
   assign alu_select = out_q.sel;
   assign dest_reg   = out_q.dest;
   assign illegal    = out_q.illegal;

endmodule
